// File: rtl/lockout_alarm_ctrl_pkg.sv
// Shared definitions for the locker lockout/alarm stage: FSM states, the verdict
// encoding shared with the door FSM, and a counter-width helper.
package lockout_alarm_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b001,
    ST_OPEN    = 3'b010,
    ST_LOCKOUT = 3'b100
  } state_e;

  typedef enum logic [1:0] {
    VERDICT_NONE  = 2'b00,
    VERDICT_RIGHT = 2'b01,
    VERDICT_WRONG = 2'b10
  } verdict_e;

  function automatic int unsigned cnt_w(input int unsigned max_load);
    return (max_load == 0) ? 1 : $clog2(max_load + 1);
  endfunction

  // A simultaneous right/wrong pair resolves to wrong so a glitching FSM cannot open the door.
  function automatic verdict_e verdict_of(input logic right_ev, input logic wrong_ev);
    if (wrong_ev)      return VERDICT_WRONG;
    else if (right_ev) return VERDICT_RIGHT;
    else               return VERDICT_NONE;
  endfunction

endpackage

// File: rtl/lockout_alarm_ctrl_edge_pulse.sv
// Rising-edge detector: one-cycle pulse per low-to-high transition of a level input.
module edge_pulse (
  input  logic clock,
  input  logic clear,
  input  logic in,
  output logic pulse
);

  logic r_q;

  // History clears to 0, so a level already high when clear drops counts as an edge.
  always_ff @(posedge clock) begin
    if (clear) r_q <= 1'b0;
    else       r_q <= in;
  end

  assign pulse = in & ~r_q;

endmodule

// File: rtl/lockout_alarm_ctrl.sv
// Lockout/alarm stage after the locker door FSM: wrong-try counting, door-open hold,
// lockout with pulsed buzzer. Optional feature macro: WRONG_CHIRP_EN (short chirp per wrong try).
module lockout_alarm_ctrl
  import lockout_alarm_ctrl_pkg::*;
#(
  parameter  int unsigned MAX_TRIES   = 3,
  parameter  int unsigned LOCK_CYCLES = 1000,
  parameter  int unsigned BEEP_HALF   = 50,
  parameter  int unsigned OPEN_CYCLES = 200,
  localparam int unsigned TRY_W       = $clog2(MAX_TRIES + 1)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             LED_right,
  input  logic             LED_wrong,
  output logic             door_open,
  output logic             lockout,
  output logic             buzzer,
  output logic [TRY_W-1:0] tries_left
);

  localparam int unsigned LOCK_W = cnt_w(LOCK_CYCLES - 1);
  localparam int unsigned BEEP_W = cnt_w(BEEP_HALF - 1);
  localparam int unsigned OPEN_W = cnt_w(OPEN_CYCLES - 1);

  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [BEEP_W-1:0] BEEP_LOAD = BEEP_W'(BEEP_HALF - 1);
  localparam logic [OPEN_W-1:0] OPEN_LOAD = OPEN_W'(OPEN_CYCLES - 1);
  localparam logic [TRY_W-1:0]  LAST_TRY  = TRY_W'(MAX_TRIES - 1);
  localparam logic [TRY_W-1:0]  TRY_MAX   = TRY_W'(MAX_TRIES);

  logic w_right_ev, w_wrong_ev;
  verdict_e w_verdict;

  state_e              r_state,     w_state;
  logic [LOCK_W-1:0]   r_lock_tmr,  w_lock_tmr;
  logic [BEEP_W-1:0]   r_beep_tmr,  w_beep_tmr;
  logic [OPEN_W-1:0]   r_open_tmr,  w_open_tmr;
  logic [TRY_W-1:0]    r_fail_cnt,  w_fail_cnt;
  logic                r_door_open, w_door_open;
  logic                r_lockout,   w_lockout;
  logic                r_buzzer,    w_buzzer;

  edge_pulse u_right_edge (
    .clock (clock),
    .clear (clear),
    .in    (LED_right),
    .pulse (w_right_ev)
  );

  edge_pulse u_wrong_edge (
    .clock (clock),
    .clear (clear),
    .in    (LED_wrong),
    .pulse (w_wrong_ev)
  );

  assign w_verdict = verdict_of(w_right_ev, w_wrong_ev);

  always_comb begin
    w_state     = r_state;
    w_lock_tmr  = r_lock_tmr;
    w_beep_tmr  = r_beep_tmr;
    w_open_tmr  = r_open_tmr;
    w_fail_cnt  = r_fail_cnt;
    w_door_open = r_door_open;
    w_lockout   = r_lockout;
    w_buzzer    = r_buzzer;

    case (r_state)
      ST_IDLE: begin
`ifdef WRONG_CHIRP_EN
        // In IDLE the buzzer is only ever high for a chirp, so it doubles as the chirp flag.
        if (r_buzzer) begin
          if (r_beep_tmr == '0) w_buzzer   = 1'b0;
          else                  w_beep_tmr = r_beep_tmr - 1'b1;
        end
`endif
        case (w_verdict)
          VERDICT_WRONG: begin
            if (r_fail_cnt == LAST_TRY) begin
              w_state    = ST_LOCKOUT;
              w_lockout  = 1'b1;
              w_buzzer   = 1'b1;
              w_lock_tmr = LOCK_LOAD;
              w_beep_tmr = BEEP_LOAD;
              w_fail_cnt = TRY_MAX;
            end else begin
              w_fail_cnt = r_fail_cnt + 1'b1;
`ifdef WRONG_CHIRP_EN
              w_buzzer   = 1'b1;
              w_beep_tmr = BEEP_LOAD;
`endif
            end
          end
          VERDICT_RIGHT: begin
            w_state     = ST_OPEN;
            w_fail_cnt  = '0;
            w_door_open = 1'b1;
            w_open_tmr  = OPEN_LOAD;
            w_buzzer    = 1'b0;
          end
          default: ;
        endcase
      end

      ST_OPEN: begin
        if (r_open_tmr == '0) begin
          w_state     = ST_IDLE;
          w_door_open = 1'b0;
        end else begin
          w_open_tmr  = r_open_tmr - 1'b1;
        end
      end

      ST_LOCKOUT: begin
        if (r_lock_tmr == '0) begin
          w_state    = ST_IDLE;
          w_lockout  = 1'b0;
          w_buzzer   = 1'b0;
          w_fail_cnt = '0;
        end else begin
          w_lock_tmr = r_lock_tmr - 1'b1;
          if (r_beep_tmr == '0) begin
            w_buzzer   = ~r_buzzer;
            w_beep_tmr = BEEP_LOAD;
          end else begin
            w_beep_tmr = r_beep_tmr - 1'b1;
          end
        end
      end

      default: begin
        w_state     = ST_IDLE;
        w_lock_tmr  = '0;
        w_beep_tmr  = '0;
        w_open_tmr  = '0;
        w_fail_cnt  = '0;
        w_door_open = 1'b0;
        w_lockout   = 1'b0;
        w_buzzer    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state     <= ST_IDLE;
      r_lock_tmr  <= '0;
      r_beep_tmr  <= '0;
      r_open_tmr  <= '0;
      r_fail_cnt  <= '0;
      r_door_open <= 1'b0;
      r_lockout   <= 1'b0;
      r_buzzer    <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_lock_tmr  <= w_lock_tmr;
      r_beep_tmr  <= w_beep_tmr;
      r_open_tmr  <= w_open_tmr;
      r_fail_cnt  <= w_fail_cnt;
      r_door_open <= w_door_open;
      r_lockout   <= w_lockout;
      r_buzzer    <= w_buzzer;
    end
  end

  assign door_open  = r_door_open;
  assign lockout    = r_lockout;
  assign buzzer     = r_buzzer;
  assign tries_left = TRY_MAX - r_fail_cnt;

endmodule

// File: tb/tb_lockout_alarm_ctrl.sv
// Scoreboard bench for lockout_alarm_ctrl: directed scenarios plus random verdict traffic
// against a cycle-count reference model of the lockout/door/buzzer rules.
module tb_lockout_alarm_ctrl;

  localparam int MAX_TRIES   = 3;
  localparam int LOCK_CYCLES = 20;
  localparam int BEEP_HALF   = 2;
  localparam int OPEN_CYCLES = 5;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic       LED_right = 1'b0;
  logic       LED_wrong = 1'b0;
  logic       door_open, lockout, buzzer;
  logic [1:0] tries_left;

  typedef struct {
    logic door_open;
    logic lockout;
    logic buzzer;
    int   tries_left;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: plain counters of remaining/elapsed cycles, -1 meaning "not locked".
  int m_fails    = 0;
  int m_open_rem = 0;
  int m_lock_age = -1;
  int m_chirp    = 0;
  bit m_prev_r   = 1'b0;
  bit m_prev_w   = 1'b0;

  lockout_alarm_ctrl #(
    .MAX_TRIES   (MAX_TRIES),
    .LOCK_CYCLES (LOCK_CYCLES),
    .BEEP_HALF   (BEEP_HALF),
    .OPEN_CYCLES (OPEN_CYCLES)
  ) dut (
    .clock      (clock),
    .clear      (clear),
    .LED_right  (LED_right),
    .LED_wrong  (LED_wrong),
    .door_open  (door_open),
    .lockout    (lockout),
    .buzzer     (buzzer),
    .tries_left (tries_left)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic model_step(input bit c, input bit r, input bit w);
    bit   rev, wev;
    exp_t e;
    if (c) begin
      m_fails = 0; m_open_rem = 0; m_lock_age = -1; m_chirp = 0;
      m_prev_r = 1'b0; m_prev_w = 1'b0;
    end else begin
      rev = r && !m_prev_r;
      wev = w && !m_prev_w;
      m_prev_r = r;
      m_prev_w = w;
      if (m_open_rem > 0) begin
        m_open_rem--;
      end else if (m_lock_age >= 0) begin
        m_lock_age++;
        if (m_lock_age == LOCK_CYCLES) begin
          m_lock_age = -1;
          m_fails    = 0;
        end
      end else begin
        if (m_chirp > 0) m_chirp--;
        if (wev) begin
          if (m_fails + 1 < MAX_TRIES) begin
            m_fails++;
`ifdef WRONG_CHIRP_EN
            m_chirp = BEEP_HALF;
`endif
          end else begin
            m_fails    = MAX_TRIES;
            m_lock_age = 0;
            m_chirp    = 0;
          end
        end else if (rev) begin
          m_fails    = 0;
          m_open_rem = OPEN_CYCLES;
          m_chirp    = 0;
        end
      end
    end
    e.door_open  = (m_open_rem > 0);
    e.lockout    = (m_lock_age >= 0);
    e.buzzer     = (m_lock_age >= 0) ? (((m_lock_age / BEEP_HALF) % 2) == 0) : (m_chirp > 0);
    e.tries_left = MAX_TRIES - m_fails;
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit c, input bit r, input bit w);
    clear     = c;
    LED_right = r;
    LED_wrong = w;
    @(posedge clock);
    model_step(c, r, w);
    @(negedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse_right();
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse_wrong();
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic check1(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, req);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check1("door_open",  32'(door_open),  32'(e.door_open));
      check1("lockout",    32'(lockout),    32'(e.lockout));
      check1("buzzer",     32'(buzzer),     32'(e.buzzer));
      check1("tries_left", 32'(tries_left), 32'(e.tries_left));
    end
  end

  initial begin
    bit c, r, w;
    @(negedge clock);
    #1;
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);

    pulse_right();
    idle(7);

    pulse_wrong(); idle(2);
    pulse_wrong(); idle(2);
    pulse_right(); idle(7);

    pulse_wrong(); pulse_wrong(); pulse_wrong();
    idle(24);

    pulse_wrong(); pulse_wrong(); pulse_wrong();
    pulse_right();
    repeat (4) drive(1'b0, 1'b0, 1'b1);
    idle(3);
    pulse_wrong();
    idle(20);
    repeat (4) drive(1'b0, 1'b0, 1'b1);
    idle(3);

    pulse_wrong();
    pulse_wrong();
    idle(5);
    drive(1'b1, 1'b0, 1'b0);
    idle(3);

    drive(1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    idle(4);
    drive(1'b0, 1'b1, 1'b1);
    idle(8);

    repeat (500) begin
      c = ($urandom_range(0, 99) == 0);
      r = ($urandom_range(0, 9) == 0);
      w = ($urandom_range(0, 5) == 0);
      drive(c, r, w);
    end
    idle(4);

    repeat (2) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
